// File: rtl/spi_config_master_if.sv
// rtl/spi_config_master_if.sv - host and SPI signal bundle for spi_config_master
// Signals: start/cmd/addr/byte_count frame request; tx_data/tx_valid/tx_ready byte source;
//          rx_data/rx_valid captured bytes; busy/done/ack_timeout status;
//          SCLK/MOSI/SS/MISO serial lines; spi_instruction_done slave acknowledge.
// Modports: master (the SPI master block), slave (host/harness side driving the requests).
interface spi_config_master_if;
    logic       start;
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] byte_count;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       ack_timeout;
    logic       SCLK;
    logic       MOSI;
    logic       SS;
    logic       MISO;
    logic       spi_instruction_done;

    modport master (
        input  start, cmd, addr, byte_count, tx_data, tx_valid, MISO, spi_instruction_done,
        output tx_ready, rx_data, rx_valid, busy, done, ack_timeout, SCLK, MOSI, SS
    );

    modport slave (
        output start, cmd, addr, byte_count, tx_data, tx_valid, MISO, spi_instruction_done,
        input  tx_ready, rx_data, rx_valid, busy, done, ack_timeout, SCLK, MOSI, SS
    );
endinterface

// File: rtl/spi_config_master.sv
// rtl/spi_config_master.sv - SPI mode-0 configuration master sending cmd, addr and streamed data bytes
// Optional macro: SPI_DONE_WAIT_EN - after SS rises, wait for the synchronized slave
//                 acknowledge (spi_instruction_done) with a TIMEOUT_CYCLES limit.
// Ports: clk, reset (synchronous, active-high);
//        bus (spi_config_master_if.master): start/cmd/addr/byte_count request, tx_data/tx_valid/tx_ready
//        byte source, rx_data/rx_valid captured bytes, busy/done/ack_timeout status,
//        SCLK/MOSI/SS/MISO serial lines, spi_instruction_done acknowledge.
module spi_config_master #(
    parameter int CLK_DIV        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    spi_config_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        ACK_WAIT,
        FINISH
    } state_t;

    state_t     state;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [7:0] addr_q;
    logic [7:0] rem_q;
    logic       on_cmd;
    logic       last_q;
    logic       sclk_q;
    logic       mosi_q;
    logic       ss_q;
    logic       busy_q;
    logic       done_q;
    logic       tx_ready_q;
    logic       rx_valid_q;
    logic [7:0] rx_data_q;
    logic       ack_timeout_q;
    logic       div_end;

    assign div_end = (div_cnt == 8'(CLK_DIV - 1));

`ifdef SPI_DONE_WAIT_EN
    logic        ack_meta;
    logic        ack_sync;
    logic [31:0] ack_cnt;

    // spi_instruction_done comes from the slave's clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_meta <= bus.spi_instruction_done;
            ack_sync <= ack_meta;
        end
    end
`else
    logic unused_ack;
    assign unused_ack = bus.spi_instruction_done ^ (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            tx_sh         <= '0;
            rx_sh         <= '0;
            addr_q        <= '0;
            rem_q         <= '0;
            on_cmd        <= 1'b0;
            last_q        <= 1'b0;
            sclk_q        <= 1'b0;
            mosi_q        <= 1'b0;
            ss_q          <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tx_ready_q    <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= '0;
            ack_timeout_q <= 1'b0;
`ifdef SPI_DONE_WAIT_EN
            ack_cnt       <= '0;
`endif
        end else begin
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            div_cnt    <= div_cnt + 8'd1;
            case (state)
                // FINISH has busy=0, so it accepts a new request exactly like IDLE.
                IDLE, FINISH: begin
                    state   <= IDLE;
                    div_cnt <= '0;
                    if (bus.start) begin
                        addr_q        <= bus.addr;
                        rem_q         <= bus.byte_count;
                        tx_sh         <= bus.cmd;
                        mosi_q        <= bus.cmd[7];
                        on_cmd        <= 1'b1;
                        last_q        <= 1'b0;
                        bit_cnt       <= '0;
                        ss_q          <= 1'b0;
                        busy_q        <= 1'b1;
                        ack_timeout_q <= 1'b0;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        sclk_q  <= 1'b1;
                        div_cnt <= '0;
                        state   <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    // First high cycle is the rising edge: sample MISO there.
                    if (div_cnt == 8'd0) begin
                        rx_sh <= {rx_sh[6:0], bus.MISO};
                    end
                    if (div_end) begin
                        sclk_q  <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 3'd1;
                        state   <= SHIFT_LO;
                        if (bit_cnt != 3'd7) begin
                            mosi_q <= tx_sh[6];
                            tx_sh  <= {tx_sh[6:0], 1'b0};
                        end else begin
                            rx_data_q  <= rx_sh;
                            rx_valid_q <= 1'b1;
                            if (on_cmd) begin
                                on_cmd <= 1'b0;
                                tx_sh  <= addr_q;
                                mosi_q <= addr_q[7];
                            end else if (rem_q != 8'd0) begin
                                // LOAD stands in for this low half-period.
                                tx_ready_q <= 1'b1;
                                state      <= LOAD;
                            end else begin
                                last_q <= 1'b1;
                            end
                        end
                    end
                end
                SHIFT_LO: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (last_q) begin
                            state <= HOLD;
                        end else begin
                            sclk_q <= 1'b1;
                            state  <= SHIFT_HI;
                        end
                    end
                end
                LOAD: begin
                    // Handshake cycle counts as the first of CLK_DIV setup cycles;
                    // an underrun just keeps the counter parked at zero.
                    if (tx_ready_q) begin
                        div_cnt <= '0;
                        if (bus.tx_valid) begin
                            tx_ready_q <= 1'b0;
                            tx_sh      <= bus.tx_data;
                            mosi_q     <= bus.tx_data[7];
                            rem_q      <= rem_q - 8'd1;
                            div_cnt    <= 8'd1;
                        end
                    end else if (div_end) begin
                        sclk_q  <= 1'b1;
                        div_cnt <= '0;
                        state   <= SHIFT_HI;
                    end
                end
                HOLD: begin
                    if (div_end) begin
                        ss_q   <= 1'b1;
                        mosi_q <= 1'b0;
`ifdef SPI_DONE_WAIT_EN
                        ack_cnt <= '0;
                        state   <= ACK_WAIT;
`else
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= FINISH;
`endif
                    end
                end
`ifdef SPI_DONE_WAIT_EN
                ACK_WAIT: begin
                    if (ack_sync || ack_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        done_q        <= 1'b1;
                        busy_q        <= 1'b0;
                        ack_timeout_q <= ~ack_sync;
                        state         <= FINISH;
                    end else begin
                        ack_cnt <= ack_cnt + 32'd1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.SCLK        = sclk_q;
    assign bus.MOSI        = mosi_q & ~ss_q;
    assign bus.SS          = ss_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.ack_timeout = ack_timeout_q;
endmodule

// File: tb/tb_spi_config_master.sv
// tb/tb_spi_config_master.sv - self-checking bench for spi_config_master
module tb_spi_config_master;
    localparam int CLK_DIV        = 2;
    localparam int TIMEOUT_CYCLES = 16;
`ifdef SPI_DONE_WAIT_EN
    localparam int   DONE_DELAY = TIMEOUT_CYCLES;
    localparam logic EXP_ATO    = 1'b1;
`else
    localparam int   DONE_DELAY = 0;
    localparam logic EXP_ATO    = 1'b0;
`endif

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [7:0]  bc;
        logic [31:0] data;
        logic        loop;
        int          stall;
        logic        restart;
        int          exp_ss;
        int          exp_rises;
        int          exp_hs;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_config_master_if bus ();

    spi_config_master #(
        .CLK_DIV       (CLK_DIV),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rx[$];
    logic [7:0] tx_bytes[4];
    logic [1:0] tx_idx = 2'd0;
    logic       loop_en = 1'b0;
    bit         hs_pend = 1'b0;
    int hs_cnt = 0, stall_left = 0, stall_bad = 0, idle_bad = 0;
    int cyc = 0, ss_low = 0, rises = 0, nbits = 0, txr_seen = 0;
    int done_cnt = 0, ss_rise_cyc = 0, done_cyc = 0;
    logic       done_ato = 1'b0;
    logic       sclk_prev = 1'b0;
    logic       ss_prev = 1'b1;
    logic [7:0] mosi_sh = 8'h00;
    vec_t       vecs[5];

    assign bus.tx_data = tx_bytes[tx_idx];
    assign bus.MISO    = loop_en & bus.MOSI;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Byte source: always valid except for a programmed stall before the second data byte.
    always @(negedge clk) begin
        if (hs_pend) begin
            tx_idx  = tx_idx + 2'd1;
            hs_pend = 1'b0;
        end
        if (bus.tx_ready && hs_cnt == 1 && stall_left > 0) begin
            bus.tx_valid = 1'b0;
            stall_left--;
            if (bus.SCLK || bus.SS) stall_bad++;
        end else begin
            bus.tx_valid = 1'b1;
        end
        if (!reset && bus.tx_ready && bus.tx_valid) begin
            hs_cnt++;
            hs_pend = 1'b1;
        end
    end

    // Line monitor: bytes on MOSI and rx strobes are popped against the scoreboard queues.
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (reset) begin
            sclk_prev = 1'b0;
            ss_prev   = 1'b1;
        end else begin
            if (!bus.SS) ss_low++;
            if (bus.SS && bus.MOSI) idle_bad++;
            if (bus.tx_ready) txr_seen++;
            if (bus.SCLK && !sclk_prev) begin
                rises++;
                mosi_sh = {mosi_sh[6:0], bus.MOSI};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (exp_mosi.size() == 0) begin
                        check("mosi_extra_byte", {24'd0, mosi_sh}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_mosi.pop_front();
                        check("mosi_byte", {24'd0, mosi_sh}, {24'd0, e});
                    end
                end
            end
            if (bus.rx_valid) begin
                if (exp_rx.size() == 0) begin
                    check("rx_extra_byte", {24'd0, bus.rx_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_rx.pop_front();
                    check("rx_byte", {24'd0, bus.rx_data}, {24'd0, e});
                end
            end
            if (bus.SS && !ss_prev) ss_rise_cyc = cyc;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                done_ato = bus.ack_timeout;
            end
            sclk_prev = bus.SCLK;
            ss_prev   = bus.SS;
        end
    end

    task automatic clear_frame(input logic [31:0] data, input int stall);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) tx_bytes[i] = data[31-8*i -: 8];
        tx_idx     = 2'd0;
        hs_pend    = 1'b0;
        hs_cnt     = 0;
        stall_left = stall;
        stall_bad  = 0;
        idle_bad   = 0;
        ss_low     = 0;
        rises      = 0;
        nbits      = 0;
        txr_seen   = 0;
        done_cnt   = 0;
        exp_mosi.delete();
        exp_rx.delete();
    endtask

    task automatic start_frame(input vec_t v);
        clear_frame(v.data, v.stall);
        loop_en = v.loop;
        exp_mosi.push_back(v.cmd);
        exp_rx.push_back(v.loop ? v.cmd : 8'h00);
        exp_mosi.push_back(v.addr);
        exp_rx.push_back(v.loop ? v.addr : 8'h00);
        for (int i = 0; i < int'(v.bc); i++) begin
            exp_mosi.push_back(tx_bytes[i]);
            exp_rx.push_back(v.loop ? tx_bytes[i] : 8'h00);
        end
        @(negedge clk);
        bus.cmd        = v.cmd;
        bus.addr       = v.addr;
        bus.byte_count = v.bc;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(input string name, input vec_t v);
        start_frame(v);
        if (v.restart) begin
            repeat (9) @(negedge clk);
            bus.cmd        = 8'hFF;
            bus.addr       = 8'h00;
            bus.byte_count = 8'd5;
            bus.start      = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_done(name);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_rises"}, rises, v.exp_rises);
        check({name, "_ss_low"}, ss_low, v.exp_ss);
        check({name, "_handshakes"}, hs_cnt, v.exp_hs);
        check({name, "_tx_ready_seen"}, {31'd0, txr_seen != 0}, {31'd0, v.exp_hs != 0});
        check({name, "_mosi_left"}, exp_mosi.size(), 0);
        check({name, "_rx_left"}, exp_rx.size(), 0);
        check({name, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
        check({name, "_ss_end"}, {31'd0, bus.SS}, 32'd1);
        check({name, "_done_delay"}, done_cyc - ss_rise_cyc, DONE_DELAY);
        check({name, "_ack_timeout"}, {31'd0, done_ato}, {31'd0, EXP_ATO});
        check({name, "_stall_lines"}, stall_bad, 0);
        check({name, "_mosi_idle"}, idle_bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start                = 1'b0;
        bus.cmd                  = 8'h00;
        bus.addr                 = 8'h00;
        bus.byte_count           = 8'h00;
        bus.spi_instruction_done = 1'b0;

        vecs[0] = '{8'h01, 8'h04, 8'd2, 32'hA53C_0000, 1'b0, 0,  1'b0, 132, 32, 2};
        vecs[1] = '{8'h01, 8'h04, 8'd2, 32'hA53C_0000, 1'b1, 0,  1'b0, 132, 32, 2};
        vecs[2] = '{8'h01, 8'h04, 8'd2, 32'hA53C_0000, 1'b1, 50, 1'b0, 182, 32, 2};
        vecs[3] = '{8'h02, 8'h94, 8'd0, 32'h0000_0000, 1'b1, 0,  1'b1, 68,  16, 0};
        vecs[4] = '{8'h5A, 8'hFF, 8'd3, 32'h00FF_8100, 1'b1, 0,  1'b0, 164, 40, 3};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ss", {31'd0, bus.SS}, 32'd1);
        check("rst_sclk", {31'd0, bus.SCLK}, 32'd0);
        check("rst_mosi", {31'd0, bus.MOSI}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
        check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check("rst_ack_timeout", {31'd0, bus.ack_timeout}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

        // Reset during the third byte, then a clean frame.
        start_frame(vecs[1]);
        n = 0;
        while (rises < 17 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reached_byte3", {31'd0, rises >= 17}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ss", {31'd0, bus.SS}, 32'd1);
        check("midrst_sclk", {31'd0, bus.SCLK}, 32'd0);
        check("midrst_mosi", {31'd0, bus.MOSI}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_done", done_cnt, 0);
        run_frame("after_rst", vecs[1]);

`ifdef SPI_DONE_WAIT_EN
        // Acknowledge arrives 5 cycles after SS rises: two synchronizer stages plus one FSM cycle.
        start_frame(vecs[3]);
        repeat (2) @(negedge clk);
        check("ack_timeout_cleared", {31'd0, bus.ack_timeout}, 32'd0);
        n = 0;
        while (bus.SS == 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        bus.spi_instruction_done = 1'b1;
        wait_done("ack");
        check("ack_done_delay", done_cyc - ss_rise_cyc, 8);
        check("ack_flag", {31'd0, done_ato}, 32'd0);
        check("ack_done_count", done_cnt, 1);
        bus.spi_instruction_done = 1'b0;
        repeat (4) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_config_master.md
Name: spi_config_master

Overview:
- Host-side SPI master that drives the SNN chip's configuration SPI slave through SCLK, MOSI and SS, and captures MISO.
- Sends one frame per request: instruction byte, address byte, then byte_count data bytes streamed from a valid/ready source.
- Used by FPGA test harnesses and loader logic to write decay, threshold, div_value, weights, delays and debug config.
- Also used to read back the config image over MISO.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range 2..255.
- TIMEOUT_CYCLES, 1024: maximum wait for the slave acknowledge; used only with the optional feature.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame request; ignored while busy=1.
- cmd  in  8  instruction byte; captured on start.
- addr  in  8  start address byte; captured on start.
- byte_count  in  8  number of data bytes after addr, 0..255; captured on start.
- tx_data  in  8  next data byte.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  master requests a data byte; the byte transfers when tx_valid=1 and tx_ready=1 in the same cycle.
- rx_data  out  8  last byte shifted in from MISO.
- rx_valid  out  1  one-cycle strobe; rx_data is valid.
- busy  out  1  frame in progress.
- done  out  1  one-cycle end-of-frame strobe.
- ack_timeout  out  1  slave acknowledge timeout flag.
- SCLK  out  1  SPI clock, mode 0 (idles low).
- MOSI  out  1  serial data out, MSB first.
- SS  out  1  active-low slave select.
- MISO  in  1  serial data in.
- spi_instruction_done  in  1  slave frame-complete acknowledge; asynchronous to clk.

Behaviour:
- Reset values:
  - SS=1, SCLK=0, MOSI=0.
  - busy=0, done=0, tx_ready=0, rx_valid=0, rx_data=0x00, ack_timeout=0.
  - FSM returns to IDLE, bit/byte counters clear.
  - Reset mid-frame aborts the frame: SS goes high on the next edge and no done pulse is produced.
- FSM states: IDLE, SETUP, LOAD, SHIFT_HI, SHIFT_LO, HOLD, ACK_WAIT (macro only), FINISH.
- IDLE: when start=1, latch cmd, addr and byte_count, set busy=1, go to SETUP.
- SETUP: SS=0, MOSI=cmd[7]. Lasts CLK_DIV cycles, then SHIFT_HI.
- Bit timing:
  - SHIFT_HI: SCLK=1 for CLK_DIV cycles. MISO is sampled on the cycle SCLK rises.
  - SHIFT_LO: SCLK=0 for CLK_DIV cycles. MOSI updates to the next bit on the cycle SCLK falls.
  - One bit takes 2*CLK_DIV cycles.
- Byte boundary (after the 8th falling edge):
  - rx_data is updated and rx_valid pulses for one cycle.
  - Byte sequence is cmd, addr, then byte_count data bytes.
  - If more data bytes remain, go to LOAD.
- LOAD:
  - tx_ready=1; SCLK stays low and SS stays low.
  - On the handshake cycle, MOSI=tx_data[7] and the FSM proceeds to SHIFT_HI after CLK_DIV cycles of setup.
  - Underrun: if tx_valid=0, stall indefinitely. No SCLK edges occur and SS is held low.
  - With no stall, LOAD consumes exactly the SHIFT_LO half-period of bit 0, so byte-to-byte timing is seamless.
- After the last byte: HOLD keeps SS low for CLK_DIV cycles, then SS=1.
- FINISH (no macro): on the cycle SS returns high, done=1 and busy=0.
- Frame length with no stalls: SS low for 2*CLK_DIV + 16*CLK_DIV*(2+byte_count) cycles.
- byte_count=0 sends cmd and addr only; tx_ready never asserts.
- start while busy is ignored, and the captured cmd/addr/byte_count are unchanged.
- Back-to-back frames: start is accepted in the cycle after done, giving a minimum SS-high gap of 1 cycle.
- Both shift registers are 8 bits, MSB first. MOSI is forced to 0 whenever SS=1.

Optional Feature:
- Macro: SPI_DONE_WAIT_EN.
- Defined:
  - spi_instruction_done passes through a 2-flop synchronizer.
  - After SS rises, the FSM enters ACK_WAIT with busy=1.
  - If a synchronized high level arrives within TIMEOUT_CYCLES, done pulses with ack_timeout=0.
  - Otherwise, done pulses with ack_timeout=1 for that same cycle.
  - ack_timeout clears on the next start.
- Undefined:
  - spi_instruction_done is ignored; no synchronizer or timeout counter is built.
  - ack_timeout is tied to 0, and done behaves as described in FINISH.

Test Plan:
1. Basic write: CLK_DIV=2; start with cmd=0x01, addr=0x04, byte_count=2; tx_data 0xA5 then 0x3C always valid.
   Required: MOSI bits sampled on SCLK rising edges are 0x01,0x04,0xA5,0x3C MSB first; exactly 32 rising edges; SS low 132 cycles; exactly 2 tx handshakes; one done pulse.
2. Loopback: MISO tied to MOSI, same frame as test 1.
   Required: four rx_valid pulses with rx_data 0x01,0x04,0xA5,0x3C in order.
3. Underrun: hold tx_valid=0 for 50 cycles before the second data byte.
   Required: SCLK stays low and SS stays low during the stall; bit stream is unchanged; SS low 182 cycles.
4. Command only, with start repeated mid-frame: byte_count=0, cmd=0x02, addr=0x94; start pulsed again 10 cycles into the frame.
   Required: 16 SCLK rising edges, tx_ready never asserts, the second start is ignored, a single done pulse.
5. Reset mid-frame: assert reset during the third byte.
   Required: next cycle SS=1, SCLK=0, MOSI=0, busy=0, no done pulse; a subsequent frame is bit-exact.
6. SPI_DONE_WAIT_EN, TIMEOUT_CYCLES=16:
   - Acknowledge raised 5 cycles after SS rises: done pulses with ack_timeout=0.
   - Acknowledge never raised: done pulses 16 cycles after SS rises, with ack_timeout=1.
